// File: rtl/drive_pkg.sv
// drive_pkg
// Shared encodings for the H-bridge drive controller.
//   state_t    : FSM state encoding driven on the 3-bit state port
//   cmd_t      : decoded motion command (HALT / FWD / REV)
//   DIR_FWD/REV: sensor codes that select forward / reverse motion
//   decode_dir : maps a registered sensor code to a command
//   is_driving : states in which the bridges may be energised
package drive_pkg;

    typedef enum logic [2:0] {
        STOP   = 3'd0,
        ACCEL  = 3'd1,
        CRUISE = 3'd2,
        DECEL  = 3'd3,
        DEADT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_HALT = 2'd0,
        CMD_FWD  = 2'd1,
        CMD_REV  = 2'd2
    } cmd_t;

    localparam logic [3:0] DIR_FWD = 4'b0011;
    localparam logic [3:0] DIR_REV = 4'b1100;

    // Only the two exact codes move the motor; anything else means stop.
    function automatic cmd_t decode_dir(input logic [3:0] code);
        cmd_t c;
        case (code)
            DIR_FWD: c = CMD_FWD;
            DIR_REV: c = CMD_REV;
            default: c = CMD_HALT;
        endcase
        return c;
    endfunction

    function automatic logic is_driving(input state_t s);
        logic d;
        case (s)
            ACCEL, CRUISE, DECEL: d = 1'b1;
            default:              d = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/drive_ctrl_pwm_gen.sv
// pwm_gen
// Free-running 8-bit PWM with a clock prescaler.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : gate; pwm is forced low when en is 0
//   duty[7:0]  : compare value, pwm high while counter < duty
//   pwm        : registered PWM output
module pwm_gen #(
    parameter int PWM_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] duty,
    output logic       pwm
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PRE_W-1:0] pre_r;
    logic [7:0]       cnt_r;
    logic             step_s;
    logic             pwm_r;

    assign step_s = (pre_r == PRE_W'(PWM_DIV - 1));
    assign pwm    = pwm_r;

    // Prescaler, PWM counter (wraps 255->0 naturally) and registered compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r <= '0;
            cnt_r <= 8'd0;
            pwm_r <= 1'b0;
        end else begin
            pre_r <= step_s ? '0 : pre_r + PRE_W'(1);
            cnt_r <= step_s ? cnt_r + 8'd1 : cnt_r;
            pwm_r <= en && (cnt_r < duty);
        end
    end

endmodule

// File: rtl/drive_ctrl.sv
// drive_ctrl
// Soft-start / soft-stop H-bridge controller with dead-time on reversal.
//   clk, rst_n        : 25 MHz clock, asynchronous active-low reset
//   dir[3:0]          : debounced direction code from the sensor stage
//   estop             : level-sensitive emergency stop
//   ml_in1/ml_in2     : left bridge direction pins
//   mr_in1/mr_in2     : right bridge direction pins
//   pwm               : shared bridge enable
//   state[2:0]        : current FSM state
//   busy              : high in every state except STOP
module drive_ctrl
    import drive_pkg::*;
#(
    parameter int PWM_DIV   = 4,
    parameter int RAMP_DIV  = 19531,
    parameter int MAX_DUTY  = 255,
    parameter int DEAD_TIME = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dir,
    input  logic       estop,
    output logic       ml_in1,
    output logic       ml_in2,
    output logic       mr_in1,
    output logic       mr_in2,
    output logic       pwm,
    output logic [2:0] state,
    output logic       busy
);

    localparam int         RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int         DEAD_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam logic [7:0] MAX_D  = 8'(MAX_DUTY);

    logic [3:0]        dir_q_r;
    logic [RAMP_W-1:0] ramp_r;
    logic [DEAD_W-1:0] dead_r;
    logic [DEAD_W-1:0] dead_s;
    logic [7:0]        duty_r;
    logic [7:0]        duty_s;
    state_t            state_r;
    state_t            state_s;
    cmd_t              cur_dir_r;
    cmd_t              cur_dir_s;
    cmd_t              cmd_s;
    logic              tick_s;
    logic              drive_s;
    logic              ml_in1_r, ml_in2_r, mr_in1_r, mr_in2_r, busy_r;

    assign tick_s = (ramp_r == RAMP_W'(RAMP_DIV - 1));

    // Next-state, next-duty and dead-time reload; estop overrides everything.
    always_comb begin
        cmd_s     = decode_dir(dir_q_r);
        state_s   = state_r;
        duty_s    = duty_r;
        cur_dir_s = cur_dir_r;
        dead_s    = dead_r;
        if (estop) begin
            state_s = DEADT;
            duty_s  = 8'd0;
            dead_s  = DEAD_W'(DEAD_TIME - 1);
        end else begin
            case (state_r)
                STOP: begin
                    duty_s = 8'd0;
                    if (cmd_s != CMD_HALT) begin
                        cur_dir_s = cmd_s;
                        state_s   = ACCEL;
                    end else begin
                        state_s = STOP;
                    end
                end
                ACCEL: begin
                    // A changed command wins over a ramp step in the same cycle.
                    if (cmd_s != cur_dir_r) begin
                        state_s = DECEL;
                    end else begin
                        if (tick_s && (duty_r < MAX_D)) begin
                            duty_s = duty_r + 8'd1;
                        end else begin
                            duty_s = duty_r;
                        end
                        if (duty_s >= MAX_D) begin
                            state_s = CRUISE;
                        end else begin
                            state_s = ACCEL;
                        end
                    end
                end
                CRUISE: begin
                    if (cmd_s != cur_dir_r) begin
                        state_s = DECEL;
                    end else begin
                        state_s = CRUISE;
                    end
                end
                DECEL: begin
                    // Same direction requested again: ramp back up from here.
                    if (cmd_s == cur_dir_r) begin
                        state_s = ACCEL;
                    end else begin
                        if (tick_s && (duty_r != 8'd0)) begin
                            duty_s = duty_r - 8'd1;
                        end else begin
                            duty_s = duty_r;
                        end
                        if (duty_s == 8'd0) begin
                            state_s = DEADT;
                            dead_s  = DEAD_W'(DEAD_TIME - 1);
                        end else begin
                            state_s = DECEL;
                        end
                    end
                end
                DEADT: begin
                    if (dead_r == '0) begin
                        state_s = STOP;
                    end else begin
                        dead_s = dead_r - DEAD_W'(1);
                    end
                end
                default: begin
                    state_s = DEADT;
                    duty_s  = 8'd0;
                    dead_s  = DEAD_W'(DEAD_TIME - 1);
                end
            endcase
        end
        drive_s = is_driving(state_s);
    end

    // State, ramp/dead counters and pins, all registered from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q_r   <= 4'd0;
            ramp_r    <= '0;
            dead_r    <= '0;
            duty_r    <= 8'd0;
            state_r   <= STOP;
            cur_dir_r <= CMD_HALT;
            ml_in1_r  <= 1'b0;
            ml_in2_r  <= 1'b0;
            mr_in1_r  <= 1'b0;
            mr_in2_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            dir_q_r   <= dir;
            ramp_r    <= tick_s ? '0 : ramp_r + RAMP_W'(1);
            dead_r    <= dead_s;
            duty_r    <= duty_s;
            state_r   <= state_s;
            cur_dir_r <= cur_dir_s;
            ml_in1_r  <= drive_s && (cur_dir_s == CMD_FWD);
            ml_in2_r  <= drive_s && (cur_dir_s == CMD_REV);
            mr_in1_r  <= drive_s && (cur_dir_s == CMD_FWD);
            mr_in2_r  <= drive_s && (cur_dir_s == CMD_REV);
            busy_r    <= (state_s != STOP);
        end
    end

    // PWM is fed next-state values so it stays aligned with the pins.
    pwm_gen #(
        .PWM_DIV(PWM_DIV)
    ) u_pwm_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (drive_s),
        .duty (duty_s),
        .pwm  (pwm)
    );

    assign ml_in1 = ml_in1_r;
    assign ml_in2 = ml_in2_r;
    assign mr_in1 = mr_in1_r;
    assign mr_in2 = mr_in2_r;
    assign busy   = busy_r;
    assign state  = state_r;

endmodule

// File: tb/tb_drive_ctrl.sv
// tb_drive_ctrl
// Directed self-checking bench for drive_ctrl with a cycle-level behavioural
// model feeding an expected-output queue.
module tb_drive_ctrl;

    localparam int RD = 4;
    localparam int PD = 1;
    localparam int DT = 8;
    localparam int MD = 255;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] dir   = 4'd0;
    logic       estop = 1'b0;
    logic       ml_in1, ml_in2, mr_in1, mr_in2, pwm, busy;
    logic [2:0] state;

    drive_ctrl #(
        .PWM_DIV(PD), .RAMP_DIV(RD), .MAX_DUTY(MD), .DEAD_TIME(DT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dir(dir), .estop(estop),
        .ml_in1(ml_in1), .ml_in2(ml_in2), .mr_in1(mr_in1), .mr_in2(mr_in2),
        .pwm(pwm), .state(state), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] exp_q[$];
    logic [3:0] m_dirq;
    int         m_ramp, m_state, m_duty, m_cur, m_dead, m_pcnt, m_ppre;
    logic [3:0] prev_pins;

    function automatic logic [8:0] obs_now();
        return {state, busy, ml_in1, ml_in2, mr_in1, mr_in2, pwm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dirq = 4'd0; m_ramp = 0; m_state = 0; m_duty = 0; m_cur = 0;
        m_dead = 0; m_pcnt = 0; m_ppre = 0;
        prev_pins = 4'd0;
        exp_q.delete();
    endtask

    // One clock edge of the behavioural model; pushes the expected outputs.
    task automatic model_step();
        int cmd, ns, nd, nc, ndd;
        logic tick, act, f, r, p;
        logic [8:0] e;
        cmd  = (m_dirq == 4'b0011) ? 1 : ((m_dirq == 4'b1100) ? 2 : 0);
        tick = (m_ramp == RD - 1);
        ns = m_state; nd = m_duty; nc = m_cur; ndd = m_dead;
        if (estop) begin
            ns = 4; nd = 0; ndd = DT - 1;
        end else begin
            case (m_state)
                0: begin
                    nd = 0;
                    if (cmd != 0) begin nc = cmd; ns = 1; end
                end
                1: if (cmd != m_cur) ns = 3;
                   else begin
                       if (tick && m_duty < MD) nd = m_duty + 1;
                       if (nd == MD) ns = 2;
                   end
                2: if (cmd != m_cur) ns = 3;
                3: if (cmd == m_cur) ns = 1;
                   else begin
                       if (tick && m_duty > 0) nd = m_duty - 1;
                       if (nd == 0) begin ns = 4; ndd = DT - 1; end
                   end
                default: if (m_dead == 0) ns = 0; else ndd = m_dead - 1;
            endcase
        end
        act = (ns >= 1 && ns <= 3);
        f = act && (nc == 1);
        r = act && (nc == 2);
        p = act && (m_pcnt < nd);
        e = {ns[2:0], (ns != 0), f, r, f, r, p};
        exp_q.push_back(e);
        m_state = ns; m_duty = nd; m_cur = nc; m_dead = ndd;
        m_dirq = dir;
        m_ramp = tick ? 0 : m_ramp + 1;
        if (m_ppre == PD - 1) begin
            m_ppre = 0;
            m_pcnt = (m_pcnt + 1) % 256;
        end else begin
            m_ppre = m_ppre + 1;
        end
    endtask

    task automatic cyc(input int n);
        logic [8:0] e;
        logic [3:0] pins;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            e = exp_q.pop_front();
            check("cycle_outputs", obs_now(), e);
            pins = {ml_in1, ml_in2, mr_in1, mr_in2};
            check("no_flip_under_pwm",
                  ((pins != prev_pins) && pwm) ||
                  (prev_pins == 4'b1010 && pins == 4'b0101) ||
                  (prev_pins == 4'b0101 && pins == 4'b1010), 0);
            prev_pins = pins;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string tag, output int n);
        n = 0;
        while (state !== s && n < limit) begin
            cyc(1);
            n++;
        end
        check(tag, state, s);
    endtask

    task automatic wait_duty(input int d, input int limit, input string tag);
        int k;
        k = 0;
        while (m_duty != d && k < limit) begin
            cyc(1);
            k++;
        end
        check(tag, (k < limit), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        #2 rst_n = 1'b0;
        #1 check("reset_outputs", obs_now(), 9'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc(4);
        check("idle_state", state, 3'd0);
        check("idle_busy", busy, 1'b0);

        // Soft start forward.
        dir = 4'b0011;
        cyc(1);
        check("start_lat1", state, 3'd0);
        cyc(1);
        check("start_lat2", state, 3'd1);
        check("fwd_pins", {ml_in1, ml_in2, mr_in1, mr_in2}, 4'b1010);
        check("start_busy", busy, 1'b1);
        wait_state(3'd2, 1100, "reach_cruise", n);
        check("accel_time", (n >= 1017 && n <= 1020), 1);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            if (pwm === 1'b1) hi++;
        end
        check("cruise_duty_255", hi, 255);

        // Reversal forward -> reverse.
        dir = 4'b1100;
        cyc(2);
        check("rev_decel", state, 3'd3);
        wait_state(3'd4, 1100, "reach_deadt", n);
        n = 0;
        while (state === 3'd4 && n < 20) begin
            check("deadt_pins", {ml_in1, ml_in2, mr_in1, mr_in2, pwm}, 5'd0);
            cyc(1);
            n++;
        end
        check("deadt_len", n, 8);
        check("rev_stop", state, 3'd0);
        cyc(1);
        check("rev_accel", state, 3'd1);
        check("rev_pins", {ml_in1, ml_in2, mr_in1, mr_in2}, 4'b0101);

        // Resume: decel then the same direction returns.
        wait_duty(110, 600, "duty_110");
        dir = 4'b0011;
        cyc(2);
        check("resume_decel", state, 3'd3);
        wait_duty(101, 200, "duty_101");
        dir = 4'b1100;
        cyc(1);
        check("resume_hold", state, 3'd3);
        cyc(1);
        check("resume_accel", state, 3'd1);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            if (pwm === 1'b1) hi++;
        end
        check("resume_upward", (hi > 100 && hi < 200), 1);

        // Invalid code from cruise.
        wait_state(3'd2, 1100, "reach_cruise_rev", n);
        dir = 4'b0101;
        cyc(2);
        check("inv_decel", state, 3'd3);
        wait_state(3'd0, 1200, "inv_stop", n);
        cyc(10);
        check("inv_stays", state, 3'd0);
        check("inv_busy", busy, 1'b0);

        // Emergency stop during accel.
        dir = 4'b0011;
        wait_duty(50, 400, "duty_50");
        check("estop_pre", state, 3'd1);
        estop = 1'b1;
        cyc(1);
        check("estop_next", {state, ml_in1, ml_in2, mr_in1, mr_in2, pwm}, {3'd4, 5'd0});
        cyc(19);
        check("estop_held", state, 3'd4);
        estop = 1'b0;
        cyc(7);
        check("estop_rel7", state, 3'd4);
        cyc(1);
        check("estop_rel8", state, 3'd0);

        // Asynchronous reset in the middle of cruise.
        wait_state(3'd2, 1100, "reach_cruise_again", n);
        #2 rst_n = 1'b0;
        #1 check("async_reset", obs_now(), 9'd0);
        dir = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc(6);
        check("post_reset_state", state, 3'd0);
        check("post_reset_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
